dm_byte_enable_decoder: RTL and testbench
=========================================

Name: dm_byte_enable_decoder

Overview:
- Data-memory access decoder for the MEM stage of the pipelined MIPS core.
- From the low address bits and the access mode it produces a registered 4-bit byte-enable, an unaligned-access flag, an illegal-mode flag and lane-steered write data.
- It also extracts and extends read data returned by the memory one cycle later.
- Lanes are little-endian: byte lane k corresponds to address offset k.

Parameters:
- DATA_W, 32: data word width; only 32 is supported.

Ports:
- DMBD_i_Clk  in  1  rising-edge clock.
- DMBD_i_Reset  in  1  asynchronous, active-high reset.
- DMBD_i_Valid  in  1  access request this cycle.
- DMBD_i_Addr  in  2  address bits [1:0].
- DMBD_i_Mode  in  4  access mode: 0 NONE, 1 WORD, 2 HALF, 3 BYTE, 4..15 illegal.
- DMBD_i_Signed  in  1  sign-extend read data (HALF/BYTE only).
- DMBD_i_WData  in  32  store data, right-aligned.
- DMBD_i_RData  in  32  raw memory word for the previously registered access.
- DMBD_o_Valid  out  1  registered outputs describe an accepted access.
- DMBD_o_ByteEn  out  4  registered byte enables.
- DMBD_o_Unaligned  out  1  registered misalignment flag.
- DMBD_o_BadMode  out  1  registered illegal-mode flag.
- DMBD_o_WData  out  32  registered lane-steered store data.
- DMBD_o_RData  out  32  combinational extracted load data.

Behaviour:
- Reset (asynchronous, active-high): all registered outputs are 0, including the latched addr/mode/signed state. DMBD_o_RData therefore reads 0 during reset.
- Latency: one cycle. Request inputs sampled at edge N appear on the outputs after edge N.
- DMBD_i_Valid=0 at an edge: DMBD_o_Valid, ByteEn, Unaligned and BadMode become 0. WData and the latched addr/mode/signed state hold their values.
- No backpressure; a new request may be issued every cycle.
- Byte-enable decode (A = Addr):
  - NONE: ByteEn 0000, Unaligned 0.
  - WORD: ByteEn 1111 if A=0; otherwise Unaligned=1 and ByteEn 0000.
  - HALF: ByteEn 0011 at A=0 and 1100 at A=2. A[0]=1 gives Unaligned=1 and ByteEn 0000.
  - BYTE: ByteEn = 1 shifted left by A (0001, 0010, 0100, 1000). Never unaligned.
  - Illegal mode (4..15): BadMode=1, ByteEn 0000, Unaligned 0.
- Write steering:
  - WORD: WData passes through unchanged.
  - HALF: WData[15:0] is replicated into both halves.
  - BYTE: WData[7:0] is replicated into all four bytes.
  - Otherwise: WData passes through.
- Read extraction:
  - Uses the latched addr/mode/signed and the current DMBD_i_RData.
  - WORD: pass through.
  - HALF: selects RData[16*A[1] +: 16].
  - BYTE: selects RData[8*A +: 8].
  - The selected field is zero-extended, or sign-extended when the latched Signed=1.
  - NONE, illegal, or a latched unaligned access: DMBD_o_RData = 0.
- Reset asserted mid-stream clears the outputs immediately, with no clock edge needed. The first access after deassertion behaves normally.

Optional Feature:
- Macro DMBD_ERR_CNT_EN.
- Defined:
  - Adds output DMBD_o_ErrCnt (8 bits).
  - The counter increments on each accepted request (Valid=1) that is unaligned or illegal-mode.
  - It saturates at 255 and resets to 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Sweep Addr 0..3 × Mode 0..4 with Valid=1, one request per cycle. Required:
  - WORD@0 → ByteEn 1111.
  - WORD@1,2,3 → ByteEn 0000, Unaligned=1.
  - HALF@0 → 0011; HALF@2 → 1100; HALF@1,3 → Unaligned=1.
  - BYTE@k → 1<<k.
  - Mode0 → 0000.
  - Mode4 → BadMode=1.
  - All results appear one cycle after the request.
- Store steering: BYTE@3 with WData=0x000000A5 → WData_out 0xA5A5A5A5, ByteEn 1000. HALF@2 with 0x00001234 → 0x12341234, ByteEn 1100.
- Load extraction: RData=0x80FF7F01.
  - BYTE@1, signed → 0x0000007F.
  - BYTE@3, signed → 0xFFFFFF80; unsigned → 0x00000080.
  - HALF@2, signed → 0xFFFF80FF.
- Valid gating: Valid=0 with WORD@0 → o_Valid=0, ByteEn 0000.
- Reset: assert Reset asynchronously mid-request → all outputs 0 immediately. First WORD@0 after release → ByteEn 1111.
- With DMBD_ERR_CNT_EN: 3 unaligned plus 1 illegal request → ErrCnt=4. 300 errors → ErrCnt=255.

Source files
------------

// File: rtl/dm_byte_enable_decoder.sv
// dm_byte_enable_decoder: MEM-stage data-memory byte-enable decode, store steering and load extraction.
// Optional: define DMBD_ERR_CNT_EN to add a saturating 8-bit misaligned/illegal access counter.
module dm_byte_enable_decoder #(
    parameter int DATA_W = 32
) (
    input  logic              DMBD_i_Clk,
    input  logic              DMBD_i_Reset,
    input  logic              DMBD_i_Valid,
    input  logic [1:0]        DMBD_i_Addr,
    input  logic [3:0]        DMBD_i_Mode,
    input  logic              DMBD_i_Signed,
    input  logic [DATA_W-1:0] DMBD_i_WData,
    input  logic [DATA_W-1:0] DMBD_i_RData,
    output logic              DMBD_o_Valid,
    output logic [3:0]        DMBD_o_ByteEn,
    output logic              DMBD_o_Unaligned,
    output logic              DMBD_o_BadMode,
    output logic [DATA_W-1:0] DMBD_o_WData,
    output logic [DATA_W-1:0] DMBD_o_RData
`ifdef DMBD_ERR_CNT_EN
    ,
    output logic [7:0]        DMBD_o_ErrCnt
`endif
);
    localparam logic [3:0] M_WORD = 4'd1;
    localparam logic [3:0] M_HALF = 4'd2;
    localparam logic [3:0] M_BYTE = 4'd3;

    logic              valid_q, unal_q, bad_q, signed_q;
    logic [3:0]        be_q, be_d, mode_q;
    logic [1:0]        addr_q;
    logic              unal_d, bad_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       half_f;
    logic [7:0]        byte_f;

    // Decode the incoming request into byte enables, fault flags and lane-replicated store data
    always_comb begin
        be_d    = DMBD_i_Mode == M_WORD ? (DMBD_i_Addr == 2'd0 ? 4'b1111 : 4'b0000) :
                  DMBD_i_Mode == M_HALF ? (DMBD_i_Addr[0] ? 4'b0000 : DMBD_i_Addr[1] ? 4'b1100 : 4'b0011) :
                  DMBD_i_Mode == M_BYTE ? 4'b0001 << DMBD_i_Addr : 4'b0000;
        unal_d  = (DMBD_i_Mode == M_WORD && DMBD_i_Addr != 2'd0) || (DMBD_i_Mode == M_HALF && DMBD_i_Addr[0]);
        bad_d   = DMBD_i_Mode > M_BYTE;
        wdata_d = DMBD_i_Mode == M_HALF ? {2{DMBD_i_WData[15:0]}} :
                  DMBD_i_Mode == M_BYTE ? {4{DMBD_i_WData[7:0]}} : DMBD_i_WData;
    end

    // Register the decode; an idle cycle clears the strobes but keeps store data and the latched access
    always_ff @(posedge DMBD_i_Clk or posedge DMBD_i_Reset) begin
        if (DMBD_i_Reset) begin
            valid_q  <= 1'b0;
            be_q     <= '0;
            unal_q   <= 1'b0;
            bad_q    <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
            mode_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            valid_q <= DMBD_i_Valid;
            be_q    <= DMBD_i_Valid ? be_d : 4'b0000;
            unal_q  <= DMBD_i_Valid & unal_d;
            bad_q   <= DMBD_i_Valid & bad_d;
            if (DMBD_i_Valid) begin
                wdata_q  <= wdata_d;
                addr_q   <= DMBD_i_Addr;
                mode_q   <= DMBD_i_Mode;
                signed_q <= DMBD_i_Signed;
            end
        end
    end

    // Pick the addressed field from the returned word and extend it; faulting accesses read as zero
    always_comb begin
        half_f       = addr_q[1] ? DMBD_i_RData[31:16] : DMBD_i_RData[15:0];
        byte_f       = DMBD_i_RData[{addr_q, 3'b000} +: 8];
        DMBD_o_RData = mode_q == M_WORD ? (addr_q == 2'd0 ? DMBD_i_RData : '0) :
                       mode_q == M_HALF ? (addr_q[0] ? '0 : {{16{signed_q & half_f[15]}}, half_f}) :
                       mode_q == M_BYTE ? {{24{signed_q & byte_f[7]}}, byte_f} : '0;
    end

    assign DMBD_o_Valid     = valid_q;
    assign DMBD_o_ByteEn    = be_q;
    assign DMBD_o_Unaligned = unal_q;
    assign DMBD_o_BadMode   = bad_q;
    assign DMBD_o_WData     = wdata_q;

`ifdef DMBD_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count accepted faulting requests, sticking at the top value
    always_ff @(posedge DMBD_i_Clk or posedge DMBD_i_Reset) begin
        if (DMBD_i_Reset)
            err_cnt_q <= '0;
        else if (DMBD_i_Valid && (unal_d || bad_d) && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign DMBD_o_ErrCnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_dm_byte_enable_decoder.sv
// tb_dm_byte_enable_decoder: randomized and directed checks of the decoder against an arithmetic reference model.
module tb_dm_byte_enable_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_i = 1'b0, s_i = 1'b0;
    logic [1:0]  a_i = '0;
    logic [3:0]  m_i = '0;
    logic [31:0] wd_i = '0, rd_i = '0;
    logic        o_valid, o_un, o_bad;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_rd;
`ifdef DMBD_ERR_CNT_EN
    logic [7:0]  o_ec;
`endif

    int total = 0;
    int bad = 0;

    logic        e_valid, e_un, e_bad, lat_s;
    logic [3:0]  e_be, lat_m;
    logic [1:0]  lat_a;
    logic [31:0] e_wd;
    int          e_ec;

    dm_byte_enable_decoder dut (
        .DMBD_i_Clk      (clk),
        .DMBD_i_Reset    (rst),
        .DMBD_i_Valid    (v_i),
        .DMBD_i_Addr     (a_i),
        .DMBD_i_Mode     (m_i),
        .DMBD_i_Signed   (s_i),
        .DMBD_i_WData    (wd_i),
        .DMBD_i_RData    (rd_i),
        .DMBD_o_Valid    (o_valid),
        .DMBD_o_ByteEn   (o_be),
        .DMBD_o_Unaligned(o_un),
        .DMBD_o_BadMode  (o_bad),
        .DMBD_o_WData    (o_wd),
        .DMBD_o_RData    (o_rd)
`ifdef DMBD_ERR_CNT_EN
        ,
        .DMBD_o_ErrCnt   (o_ec)
`endif
    );

    always #5 clk = ~clk;

    // Access size in bytes; zero for NONE and illegal modes
    function automatic int sz(input logic [3:0] m);
        return m == 4'd1 ? 4 : m == 4'd2 ? 2 : m == 4'd3 ? 1 : 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] m, input logic [1:0] a);
        int n = sz(m);
        int ai = int'(a);
        if (n == 0 || ai % n != 0) return 4'b0000;
        return 4'(((1 << n) - 1) << ai);
    endfunction

    function automatic logic m_un(input logic [3:0] m, input logic [1:0] a);
        int n = sz(m);
        return n > 1 && (int'(a) % n) != 0;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] m, input logic [31:0] w);
        return m == 4'd2 ? w[15:0] * 32'h0001_0001 : m == 4'd3 ? w[7:0] * 32'h0101_0101 : w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] m, input logic [1:0] a, input logic s, input logic [31:0] r);
        int n = sz(m);
        int ai = int'(a);
        longint f;
        if (n == 0 || ai % n != 0) return 32'h0;
        f = (longint'({32'h0, r}) >> (8 * ai)) & ((longint'(1) << (8 * n)) - 1);
        if (s && n < 4 && f[8 * n - 1]) f = f - (longint'(1) << (8 * n));
        return f[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 0; e_un = 0; e_bad = 0; e_be = '0; e_wd = '0;
        lat_a = '0; lat_m = '0; lat_s = 0; e_ec = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(o_valid), 32'(e_valid));
        chk({tag, ".be"}, 32'(o_be), 32'(e_be));
        chk({tag, ".un"}, 32'(o_un), 32'(e_un));
        chk({tag, ".bad"}, 32'(o_bad), 32'(e_bad));
        chk({tag, ".wd"}, o_wd, e_wd);
        chk({tag, ".rd"}, o_rd, m_rd(lat_m, lat_a, lat_s, rd_i));
`ifdef DMBD_ERR_CNT_EN
        chk({tag, ".ec"}, 32'(o_ec), 32'(e_ec));
`endif
    endtask

    // Apply one request across a clock edge, then present read data and compare everything
    task automatic step(input logic v, input logic [1:0] a, input logic [3:0] m, input logic s,
                        input logic [31:0] w, input logic [31:0] r, input string tag);
        v_i = v; a_i = a; m_i = m; s_i = s; wd_i = w;
        @(posedge clk);
        e_valid = v;
        e_be    = v ? m_be(m, a) : 4'b0000;
        e_un    = v & m_un(m, a);
        e_bad   = v & (m > 4'd3);
        if (v) begin
            e_wd = m_wd(m, w); lat_a = a; lat_m = m; lat_s = s;
            if ((m_un(m, a) || m > 4'd3) && e_ec < 255) e_ec++;
        end
        #1 rd_i = r;
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        #12 rd_i = 32'hDEAD_BEEF;
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;
        for (int m = 0; m <= 4; m++)
            for (int a = 0; a < 4; a++)
                step(1'b1, 2'(a), 4'(m), 1'($urandom % 2), $urandom, $urandom, "sweep");
        step(1'b1, 2'd0, 4'd1, 1'b0, $urandom, $urandom, "w0");
        chk("w0.const", 32'(o_be), 32'hF);
        step(1'b1, 2'd3, 4'd1, 1'b0, $urandom, $urandom, "w3");
        chk("w3.const", {o_be, 3'b0, o_un}, {4'b0000, 3'b0, 1'b1});
        step(1'b1, 2'd3, 4'd3, 1'b0, 32'h0000_00A5, $urandom, "st_b3");
        chk("st_b3.wd", o_wd, 32'hA5A5_A5A5);
        chk("st_b3.be", 32'(o_be), 32'h8);
        step(1'b1, 2'd2, 4'd2, 1'b0, 32'h0000_1234, $urandom, "st_h2");
        chk("st_h2.wd", o_wd, 32'h1234_1234);
        chk("st_h2.be", 32'(o_be), 32'hC);
        step(1'b1, 2'd1, 4'd3, 1'b1, $urandom, 32'h80FF_7F01, "ld_b1s");
        chk("ld_b1s.c", o_rd, 32'h0000_007F);
        step(1'b1, 2'd3, 4'd3, 1'b1, $urandom, 32'h80FF_7F01, "ld_b3s");
        chk("ld_b3s.c", o_rd, 32'hFFFF_FF80);
        step(1'b1, 2'd3, 4'd3, 1'b0, $urandom, 32'h80FF_7F01, "ld_b3u");
        chk("ld_b3u.c", o_rd, 32'h0000_0080);
        step(1'b1, 2'd2, 4'd2, 1'b1, $urandom, 32'h80FF_7F01, "ld_h2s");
        chk("ld_h2s.c", o_rd, 32'hFFFF_80FF);
        step(1'b0, 2'd0, 4'd1, 1'b0, $urandom, $urandom, "gate");
        chk("gate.c", {31'(o_be), o_valid}, 32'h0);
        step(1'b1, 2'd0, 4'd1, 1'b0, 32'hCAFE_F00D, $urandom, "pre_rst");
        v_i = 1'b1; a_i = 2'd0; m_i = 4'd1;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        chk("async_rst.wd", o_wd, 32'h0);
        @(negedge clk) rst = 1'b0;
        step(1'b1, 2'd0, 4'd1, 1'b0, $urandom, $urandom, "post_rst");
        chk("post_rst.c", 32'(o_be), 32'hF);
`ifdef DMBD_ERR_CNT_EN
        @(negedge clk) rst = 1'b1;
        model_reset();
        @(negedge clk) rst = 1'b0;
        step(1'b1, 2'd1, 4'd1, 1'b0, $urandom, $urandom, "ec1");
        step(1'b1, 2'd1, 4'd2, 1'b0, $urandom, $urandom, "ec2");
        step(1'b1, 2'd3, 4'd2, 1'b0, $urandom, $urandom, "ec3");
        step(1'b1, 2'd0, 4'd9, 1'b0, $urandom, $urandom, "ec4");
        chk("ec4.c", 32'(o_ec), 32'd4);
        for (int i = 0; i < 300; i++)
            step(1'b1, 2'($urandom_range(1, 3)), 4'd1, 1'b0, $urandom, $urandom, "ec_sat");
        chk("ec_sat.c", 32'(o_ec), 32'd255);
`endif
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 8 != 0), 2'($urandom), ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 4),
                 1'($urandom), $urandom, $urandom, "rand");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
